capture_upsizer_deadlock_reporter: RTL and testbench
====================================================

// Module: capture_upsizer_deadlock_reporter
// PURPOSE
//  Sits directly downstream of the capture_upsizer HLS deadlock monitor and consumes its
//  block / axis_block_info outputs. Filters transient AXIS stalls, declares a deadlock only after
//  the block flag persists for PERSIST_CYCLES, and freezes a snapshot of which stream stalled.
//  Raises a sticky flag plus a one-cycle irq, and holds it until software acks.
//  Also keeps a saturating event count and the peak stall run length for debug readout.
// PARAMETERS
//  NUM_CH          2     AXIS channels watched by the monitor
//  INFO_W          4     block-info width, = 2*NUM_CH (2 bits per channel)
//  PERSIST_CYCLES  1024  consecutive block cycles required to declare deadlock (>=1)
//  CNT_W           32    width of run-length and peak counters
//  EVT_W           16    width of event counter
// PORTS
//  clock          in   1       single clock; all logic on posedge
//  reset_n        in   1       synchronous, active-low reset
//  block          in   1       monitor block flag (registered upstream)
//  block_info     in   INFO_W  monitor axis_block_info (valid when block=1)
//  ack            in   1       software acknowledge/clear of a reported deadlock
//  deadlock       out  1       sticky: high while in REPORT state
//  deadlock_info  out  INFO_W  block_info snapshot taken at the REPORT-entry edge
//  irq            out  1       one-cycle pulse on REPORT entry
//  event_count    out  EVT_W   number of REPORT entries, saturating at all-ones
//  peak_stall     out  CNT_W   longest consecutive block run seen, saturating
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE; run_cnt, peak_stall, event_count, deadlock_info=0;
//   deadlock=0, irq=0. Reset mid-REPORT drops deadlock on that same edge.
//  run_cnt: +1 each edge block=1 (saturate at 2^CNT_W-1); cleared to 0 on any edge block=0.
//  peak_stall <= max(peak_stall, run_cnt_next) every edge; never decreases except by reset.
//  States:
//   IDLE:     block=1 -> WATCH (run_cnt_next=1); if PERSIST_CYCLES==1 go straight to REPORT.
//   WATCH:    block=0 -> IDLE. block=1 and run_cnt_next==PERSIST_CYCLES -> REPORT.
//   REPORT:   deadlock=1. ack=1 -> (block=1 ? HOLDOFF : IDLE). block changes ignored.
//   HOLDOFF:  wait for block=0 -> IDLE; prevents re-trigger on the same stall episode.
//  Latency: block sampled high on edges e0..e0+P-1 (P=PERSIST_CYCLES) -> deadlock and irq
//   become 1 after edge e0+P-1; irq returns to 0 after the next edge.
//  REPORT entry edge: deadlock_info <= block_info (same-edge sample); event_count += 1 unless
//   saturated. deadlock_info holds until the next REPORT entry; it is not cleared by ack.
//  ack is a level sampled per edge and is ignored outside REPORT. ack on the REPORT-entry
//   edge itself has no effect, because the state is not yet REPORT.
//  block_info is ignored except on the REPORT-entry edge.
//  All outputs are registered; there is no combinational path from input to output.
// TESTING
//  (P=8) reset_n=0 for 2 cycles -> all outputs 0, state IDLE.
//  block=1 for 7 edges, then 0 -> deadlock=0, irq never pulses, peak_stall=7, event_count=0.
//  block=1 for 8 edges, block_info=4'b1110 -> deadlock=1 and a single irq after the 8th edge,
//   deadlock_info=4'hE, event_count=1.
//  In REPORT, block held 1, ack=1 for 1 cycle -> deadlock=0, HOLDOFF. 20 more block=1 edges
//   give no new irq. block=0 then 8 high edges -> second report, event_count=2, peak_stall=29.
//  In REPORT, block already 0, ack=1 -> IDLE directly; deadlock_info still 4'hE.
//  reset_n=0 while deadlock=1 -> deadlock, event_count, peak_stall = 0 after that edge.
//  Force event_count=16'hFFFF, trigger a report -> count stays 16'hFFFF and irq still pulses.

Source files
------------

// File: rtl/capture_upsizer_deadlock_reporter.sv
// capture_upsizer_deadlock_reporter: persistence filter on the HLS
// deadlock monitor block flag, with sticky report, irq and debug counters.
module capture_upsizer_deadlock_reporter #(
  parameter int NUM_CH         = 2,
  parameter int INFO_W         = 2 * NUM_CH,
  parameter int PERSIST_CYCLES = 1024,
  parameter int CNT_W          = 32,
  parameter int EVT_W          = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              block,
  input  logic [INFO_W-1:0] block_info,
  input  logic              ack,
  output logic              deadlock,
  output logic [INFO_W-1:0] deadlock_info,
  output logic              irq,
  output logic [EVT_W-1:0]  event_count,
  output logic [CNT_W-1:0]  peak_stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WATCH,
    S_REPORT,
    S_HOLDOFF
  } state_t;

  localparam logic [CNT_W-1:0] LP_PERSIST = CNT_W'(PERSIST_CYCLES);
  localparam logic [CNT_W-1:0] LP_RUN_MAX = '1;
  localparam logic [EVT_W-1:0] LP_EVT_MAX = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_run;
  logic [CNT_W-1:0]  w_run_nxt;
  logic [CNT_W-1:0]  r_peak;
  logic [EVT_W-1:0]  r_evt;
  logic [INFO_W-1:0] r_info;
  logic              r_deadlock;
  logic              r_irq;
  logic              w_hit;
  logic              w_enter;

  // Length of the current stall run, saturating, as of this edge.
  always_comb begin
    w_run_nxt = '0;
    if (block) begin
      if (r_run == LP_RUN_MAX) w_run_nxt = r_run;
      else w_run_nxt = r_run + CNT_W'(1);
    end
  end

  assign w_hit = block && (w_run_nxt == LP_PERSIST);

  // Next-state decode; w_enter marks the REPORT-entry edge.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (block) begin
          if (w_hit) begin
            w_state_nxt = S_REPORT;
            w_enter     = 1'b1;
          end else begin
            w_state_nxt = S_WATCH;
          end
        end
      end
      S_WATCH: begin
        if (!block) begin
          w_state_nxt = S_IDLE;
        end else if (w_hit) begin
          w_state_nxt = S_REPORT;
          w_enter     = 1'b1;
        end
      end
      S_REPORT: begin
        if (ack) w_state_nxt = block ? S_HOLDOFF : S_IDLE;
      end
      S_HOLDOFF: begin
        if (!block) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_run      <= '0;
      r_peak     <= '0;
      r_evt      <= '0;
      r_info     <= '0;
      r_deadlock <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_deadlock <= (w_state_nxt == S_REPORT);
      r_irq      <= w_enter;
      if (w_run_nxt > r_peak) r_peak <= w_run_nxt;
      if (w_enter) begin
        r_info <= block_info;
        if (r_evt != LP_EVT_MAX) r_evt <= r_evt + EVT_W'(1);
      end
    end
  end

  assign deadlock      = r_deadlock;
  assign deadlock_info = r_info;
  assign irq           = r_irq;
  assign event_count   = r_evt;
  assign peak_stall    = r_peak;

endmodule

// File: tb/tb_capture_upsizer_deadlock_reporter.sv
// tb_capture_upsizer_deadlock_reporter: directed scenarios plus random
// stall traffic against an episode-level reference model.
module tb_capture_upsizer_deadlock_reporter;

  localparam int P  = 8;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          block;
  logic [IW-1:0] block_info;
  logic          ack;
  logic          deadlock;
  logic [IW-1:0] deadlock_info;
  logic          irq;
  logic [15:0]   event_count;
  logic [31:0]   peak_stall;

  logic          b_rst_n;
  logic          b_block;
  logic [IW-1:0] b_info;
  logic          b_ack;
  logic          b_dead;
  logic [IW-1:0] b_dinfo;
  logic          b_irq;
  logic [1:0]    b_cnt;
  logic [7:0]    b_peak;

  int n_tests = 0;
  int n_fail  = 0;

  longint m_run;
  longint m_peak;
  int     m_cnt;
  int     m_info;
  bit     m_rep;
  bit     m_hold;
  bit     m_irq;

  always #5 clock = ~clock;

  capture_upsizer_deadlock_reporter #(
    .NUM_CH(2), .INFO_W(IW), .PERSIST_CYCLES(P),
    .CNT_W(32), .EVT_W(16)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .block(block),
    .block_info(block_info), .ack(ack), .deadlock(deadlock),
    .deadlock_info(deadlock_info), .irq(irq),
    .event_count(event_count), .peak_stall(peak_stall)
  );

  capture_upsizer_deadlock_reporter #(
    .NUM_CH(2), .INFO_W(IW), .PERSIST_CYCLES(2),
    .CNT_W(8), .EVT_W(2)
  ) u_sat (
    .clock(clock), .reset_n(b_rst_n), .block(b_block),
    .block_info(b_info), .ack(b_ack), .deadlock(b_dead),
    .deadlock_info(b_dinfo), .irq(b_irq),
    .event_count(b_cnt), .peak_stall(b_peak)
  );

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rn, input bit b,
                            input int inf, input bit a);
    m_irq = 0;
    if (!rn) begin
      m_run = 0; m_peak = 0; m_cnt = 0; m_info = 0;
      m_rep = 0; m_hold = 0;
    end else begin
      m_run = b ? m_run + 1 : 0;
      if (m_run > m_peak) m_peak = m_run;
      if (m_rep) begin
        if (a) begin
          m_rep  = 0;
          m_hold = b;
        end
      end else if (m_hold) begin
        if (!b) m_hold = 0;
      end else if (b && m_run == P) begin
        m_rep  = 1;
        m_irq  = 1;
        m_info = inf;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic step(input bit rn, input bit b,
                      input int inf, input bit a);
    @(negedge clock);
    reset_n    = rn;
    block      = b;
    block_info = IW'(inf);
    ack        = a;
    @(posedge clock);
    model_edge(rn, b, inf, a);
    #1;
    check("deadlock", deadlock, m_rep);
    check("irq", irq, m_irq);
    check("info", deadlock_info, m_info);
    check("evt", event_count, m_cnt);
    check("peak", peak_stall, m_peak);
  endtask

  task automatic stepb(input bit rn, input bit b, input bit a);
    @(negedge clock);
    b_rst_n = rn;
    b_block = b;
    b_ack   = a;
    b_info  = IW'($urandom);
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit rb;
    reset_n = 1'b0; block = 1'b0; block_info = '0; ack = 1'b0;
    b_rst_n = 1'b0; b_block = 1'b0; b_info = '0; b_ack = 1'b0;
    m_run = 0; m_peak = 0; m_cnt = 0; m_info = 0;
    m_rep = 0; m_hold = 0; m_irq = 0;

    step(0, 0, 0, 0);
    step(0, 1, 5, 1);
    check("rst_dead", deadlock, 0);
    check("rst_peak", peak_stall, 0);

    for (int i = 0; i < 7; i++) step(1, 1, 3, 0);
    step(1, 0, 3, 0);
    check("short_dead", deadlock, 0);
    check("short_peak", peak_stall, 7);
    check("short_evt", event_count, 0);

    for (int i = 0; i < 7; i++) step(1, 1, 2, 0);
    check("pre_dead", deadlock, 0);
    step(1, 1, 14, 0);
    check("rep_dead", deadlock, 1);
    check("rep_irq", irq, 1);
    check("rep_info", deadlock_info, 4'hE);
    check("rep_evt", event_count, 1);

    step(1, 1, 7, 1);
    check("ack_dead", deadlock, 0);
    check("ack_irq", irq, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 9, 0);
      check("hold_irq", irq, 0);
    end
    step(1, 0, 9, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 14, 0);
    check("rep2_irq", irq, 1);
    check("rep2_evt", event_count, 2);
    check("rep2_peak", peak_stall, 29);

    step(1, 0, 1, 0);
    check("rep2_stay", deadlock, 1);
    step(1, 0, 1, 1);
    check("idle_dead", deadlock, 0);
    check("idle_info", deadlock_info, 4'hE);
    for (int i = 0; i < 8; i++) step(1, 1, 6, 0);
    check("rep3_irq", irq, 1);

    step(0, 1, 6, 0);
    check("mid_rst_dead", deadlock, 0);
    check("mid_rst_evt", event_count, 0);
    check("mid_rst_peak", peak_stall, 0);

    rb = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      step(($urandom_range(0, 399) != 0), rb, int'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0));
    end

    stepb(0, 0, 0);
    stepb(0, 0, 0);
    check("sat_rst", b_cnt, 0);
    for (int k = 1; k <= 5; k++) begin
      stepb(1, 1, 0);
      check("sat_pre", b_irq, 0);
      stepb(1, 1, 0);
      check("sat_irq", b_irq, 1);
      check("sat_dead", b_dead, 1);
      check("sat_cnt", b_cnt, (k > 3) ? 3 : k);
      stepb(1, 0, 1);
      check("sat_ack", b_dead, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
